// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  // Instruction addresses are word aligned; low two bits are forced to zero.
  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// Single-entry holding register for a fetched word that arrived during a stall.
module fetch_skid_buf
  import if_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [INSTR_W-1:0] plus4_i,
  output logic [INSTR_W-1:0] data_o,
  output logic [INSTR_W-1:0] plus4_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] data_q;
  logic [INSTR_W-1:0] plus4_q;
  logic               valid_q;

  // Clear wins over load so a redirect always empties the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= NOP_INSTR;
      plus4_q <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      data_q  <= NOP_INSTR;
      plus4_q <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      plus4_q <= plus4_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign plus4_o = plus4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ack handshake and
// feeds the IF/ID register, handling stalls, redirects and stale responses.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instru_addr_plus4,
  output logic        if_valid
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               req_q, req_d;
  logic [INSTR_W-1:0] addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] plus4_q, plus4_d;
  logic               valid_q, valid_d;

  logic               skid_load, skid_clear, skid_valid;
  logic [INSTR_W-1:0] skid_data, skid_plus4;
  logic               ack_c;
  logic [INSTR_W-1:0] pc_inc, redir_pc;

  assign ack_c    = imem_ack & req_q;
  assign pc_inc   = pc_q + PC_INC;
  assign redir_pc = align_pc(redirect_addr);

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (imem_rdata),
    .plus4_i (pc_inc),
    .data_o  (skid_data),
    .plus4_o (skid_plus4),
    .valid_o (skid_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= START;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
      plus4_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      plus4_q <= plus4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    plus4_d    = plus4_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    // Unstalled outputs show a bubble unless a word is delivered below.
    if (!stall) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    if (redirect_valid) begin
      pc_d       = redir_pc;
      instr_d    = NOP_INSTR;
      plus4_d    = '0;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      // An unanswered request must finish at its old address before refetching.
      if ((state_q == FETCH || state_q == DROP) && !ack_c) begin
        state_d = DROP;
      end else begin
        req_d   = 1'b1;
        addr_d  = redir_pc;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        START: begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH;
        end
        FETCH: begin
          if (ack_c) begin
            if (stall) begin
              skid_load = 1'b1;
              req_d     = 1'b0;
              state_d   = HOLD;
            end else begin
              instr_d = imem_rdata;
              plus4_d = pc_inc;
              valid_d = 1'b1;
              pc_d    = pc_inc;
              addr_d  = pc_inc;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d    = skid_data;
            plus4_d    = skid_plus4;
            valid_d    = skid_valid;
            skid_clear = 1'b1;
            pc_d       = pc_inc;
            req_d      = 1'b1;
            addr_d     = pc_inc;
            state_d    = FETCH;
          end
        end
        DROP: begin
          if (ack_c) begin
            addr_d  = pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = START;
      endcase
    end
  end

  assign imem_req          = req_q;
  assign imem_addr         = addr_q;
  assign instruction       = instr_q;
  assign instru_addr_plus4 = plus4_q;
  assign if_valid          = valid_q;

endmodule
